visor_division: RTL

VISOR_DIVISION -- requirements
Module: visor_division

---
 rtl/visor_division_if.sv | 22 ++
 rtl/visor_division.sv | 131 +++++++++++++
 2 files changed

// File: rtl/visor_division_if.sv
// Bus between the divider stage and the multiplexed four-digit visor.
// master drives the divider result side; slave is the display block.
interface visor_division_if;
    logic       hecho;
    logic [3:0] resultado;
    logic [3:0] resto;
    logic [3:0] denominador;
    logic       borrar;
    logic [6:0] seg;
    logic [3:0] anodo;
    logic       valido;

    modport master (
        output hecho, resultado, resto, denominador, borrar,
        input  seg, anodo, valido
    );

    modport slave (
        input  hecho, resultado, resto, denominador, borrar,
        output seg, anodo, valido
    );
endinterface

// File: rtl/visor_division.sv
// Four-digit multiplexed 7-segment visor for a 4-bit divider (quotient/remainder).
// Define DIV_CERO_EN to show "Err" when a result is captured with a zero divisor.
module visor_division #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    visor_division_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic             hecho_prev_q;
    logic [3:0]       res_q, res_d;
    logic [3:0]       rem_q, rem_d;
    logic             err_q, err_d;
    logic             valido_q, valido_d;
    logic             capture;
    logic             wrap;
    logic [3:0]       digit_val;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] units(input logic [3:0] v);
        units = (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

    function automatic logic [3:0] tens(input logic [3:0] v);
        tens = (v >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    assign capture = bus.hecho & ~hecho_prev_q;
    assign wrap    = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        dig_d    = wrap ? dig_q + 2'd1 : dig_q;
        valido_d = valido_q;
        res_d    = res_q;
        rem_d    = rem_q;
        err_d    = err_q;
        // Clear wins over a coincident capture and leaves the latched result alone.
        if (bus.borrar) begin
            valido_d = 1'b0;
        end else if (capture) begin
            valido_d = 1'b1;
            res_d    = bus.resultado;
            rem_d    = bus.resto;
`ifdef DIV_CERO_EN
            err_d    = (bus.denominador == 4'd0);
`else
            err_d    = 1'b0;
`endif
        end
    end

`ifndef DIV_CERO_EN
    logic unused_denominador;
    assign unused_denominador = ^bus.denominador;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_q        <= 2'd0;
            hecho_prev_q <= 1'b0;
            res_q        <= 4'd0;
            rem_q        <= 4'd0;
            err_q        <= 1'b0;
            valido_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            hecho_prev_q <= bus.hecho;
            res_q        <= res_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            valido_q     <= valido_d;
        end
    end

    always_comb begin
        case (dig_q)
            2'd0:    digit_val = units(rem_q);
            2'd1:    digit_val = tens(rem_q);
            2'd2:    digit_val = units(res_q);
            default: digit_val = tens(res_q);
        endcase
    end

    always_comb begin
        bus.anodo = ~(4'b0001 << dig_q);
        if (!valido_q) begin
            bus.seg = SEG_DASH;
        end else if (err_q) begin
            case (dig_q)
                2'd0:    bus.seg = SEG_BLANK;
                2'd1:    bus.seg = SEG_R;
                2'd2:    bus.seg = SEG_R;
                default: bus.seg = SEG_E;
            endcase
        end else begin
            bus.seg = seg7(digit_val);
        end
    end

    assign bus.valido = valido_q;

endmodule
